// File: rtl/ibex_uarch_fcov_probe_pkg.sv
// ibex_uarch_fcov_pkg: shared types for the micro-architectural coverage probe.
package ibex_uarch_fcov_pkg;

    typedef enum logic [2:0] {
        STALL_NONE    = 3'd0,
        STALL_LD_HZ   = 3'd1,
        STALL_MEM     = 3'd2,
        STALL_MULTDIV = 3'd3,
        STALL_JUMP    = 3'd4,
        STALL_BRANCH  = 3'd5,
        STALL_OTHER   = 3'd6
    } stall_cause_e;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } probe_state_e;

    // OTHER is deliberately left out of the histogram
    localparam int NumStallCauses = 6;

endpackage

// File: rtl/ibex_uarch_fcov_probe_if.sv
// ibex_uarch_fcov_probe_if: raw pipeline probes in, registered coverage signals out.
interface ibex_uarch_fcov_probe_if #(
    parameter int StallCntW = 8,
    parameter int HistCntW  = 32
) ();
    logic                  if_valid_i;
    logic                  id_valid_i;
    logic                  id_done_i;
    logic                  wb_valid_i;
    logic [31:0]           id_instr_i;
    logic                  ld_hz_i;
    logic                  lsu_busy_i;
    logic                  multdiv_busy_i;
    logic                  jump_i;
    logic                  branch_i;
    logic                  valid_if_o;
    logic                  valid_id_o;
    logic                  valid_wb_o;
    logic [31:0]           instr_id_o;
    logic                  stall_id_ld_hz_o;
    logic                  stall_id_mem_o;
    logic                  stall_id_multdiv_o;
    logic                  stall_id_jump_o;
    logic                  stall_id_branch_o;
    logic                  summary_valid_o;
    logic [2:0]            summary_cause_o;
    logic [StallCntW-1:0]  summary_cycles_o;
    logic [6*HistCntW-1:0] hist_o;

    modport master (
        input  if_valid_i, id_valid_i, id_done_i, wb_valid_i, id_instr_i,
               ld_hz_i, lsu_busy_i, multdiv_busy_i, jump_i, branch_i,
        output valid_if_o, valid_id_o, valid_wb_o, instr_id_o,
               stall_id_ld_hz_o, stall_id_mem_o, stall_id_multdiv_o,
               stall_id_jump_o, stall_id_branch_o,
               summary_valid_o, summary_cause_o, summary_cycles_o, hist_o
    );

    modport slave (
        output if_valid_i, id_valid_i, id_done_i, wb_valid_i, id_instr_i,
               ld_hz_i, lsu_busy_i, multdiv_busy_i, jump_i, branch_i,
        input  valid_if_o, valid_id_o, valid_wb_o, instr_id_o,
               stall_id_ld_hz_o, stall_id_mem_o, stall_id_multdiv_o,
               stall_id_jump_o, stall_id_branch_o,
               summary_valid_o, summary_cause_o, summary_cycles_o, hist_o
    );
endinterface

// File: rtl/ibex_uarch_fcov_probe_sat_counter.sv
// ibex_fcov_sat_counter: up-counter that sticks at all-ones, with synchronous clear.
module ibex_fcov_sat_counter #(
    parameter int Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear,
    input  logic             incr,
    output logic [Width-1:0] count
);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                  count <= '0;
        else if (clear)               count <= '0;
        else if (incr && count != '1) count <= count + 1'b1;
    end
endmodule

// File: rtl/ibex_uarch_fcov_probe.sv
// ibex_uarch_fcov_probe: registers core probes for coverage and summarises ID stalls per instruction.
// Optional per-cause histogram enabled by IBEX_FCOV_STALL_HIST_EN.
module ibex_uarch_fcov_probe
    import ibex_uarch_fcov_pkg::*;
#(
    parameter int StallCntW = 8,
    parameter int HistCntW  = 32
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    ibex_uarch_fcov_probe_if.master bus
);
    probe_state_e         state_q, state_d;
    stall_cause_e         cause_d, first_cause_q, sum_cause_d;
    logic                 stalled, sum_valid_d, load_first;
    logic [StallCntW-1:0] cnt;

    assign stalled = bus.id_valid_i & ~bus.id_done_i;
    assign cause_d = !stalled           ? STALL_NONE    :
                     bus.ld_hz_i        ? STALL_LD_HZ   :
                     bus.lsu_busy_i     ? STALL_MEM     :
                     bus.multdiv_busy_i ? STALL_MULTDIV :
                     bus.jump_i         ? STALL_JUMP    :
                     bus.branch_i       ? STALL_BRANCH  : STALL_OTHER;

    always_comb begin
        state_d     = state_q;
        sum_valid_d = 1'b0;
        sum_cause_d = STALL_NONE;
        load_first  = 1'b0;
        case (state_q)
            IDLE: begin
                if (stalled) begin
                    state_d    = STALL;
                    load_first = 1'b1;
                end else if (bus.id_valid_i) begin
                    sum_valid_d = 1'b1;
                end
            end
            STALL: begin
                if (!bus.id_valid_i) begin
                    state_d = IDLE;
                end else if (bus.id_done_i) begin
                    state_d     = IDLE;
                    sum_valid_d = 1'b1;
                    sum_cause_d = first_cause_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The counter sits at 0 whenever ID is not stalled, so entering STALL lands on 1
    ibex_fcov_sat_counter #(.Width(StallCntW)) u_stall_cnt (
        .clk_i,
        .rst_ni,
        .clear (~stalled),
        .incr  (stalled),
        .count (cnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            first_cause_q <= STALL_NONE;
        end else begin
            state_q <= state_d;
            if (load_first) first_cause_q <= cause_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.valid_if_o         <= 1'b0;
            bus.valid_id_o         <= 1'b0;
            bus.valid_wb_o         <= 1'b0;
            bus.instr_id_o         <= '0;
            bus.stall_id_ld_hz_o   <= 1'b0;
            bus.stall_id_mem_o     <= 1'b0;
            bus.stall_id_multdiv_o <= 1'b0;
            bus.stall_id_jump_o    <= 1'b0;
            bus.stall_id_branch_o  <= 1'b0;
            bus.summary_valid_o    <= 1'b0;
            bus.summary_cause_o    <= '0;
            bus.summary_cycles_o   <= '0;
        end else begin
            bus.valid_if_o         <= bus.if_valid_i;
            bus.valid_id_o         <= bus.id_valid_i;
            bus.valid_wb_o         <= bus.wb_valid_i;
            bus.stall_id_ld_hz_o   <= cause_d == STALL_LD_HZ;
            bus.stall_id_mem_o     <= cause_d == STALL_MEM;
            bus.stall_id_multdiv_o <= cause_d == STALL_MULTDIV;
            bus.stall_id_jump_o    <= cause_d == STALL_JUMP;
            bus.stall_id_branch_o  <= cause_d == STALL_BRANCH;
            bus.summary_valid_o    <= sum_valid_d;
            if (bus.id_valid_i) bus.instr_id_o <= bus.id_instr_i;
            if (sum_valid_d) begin
                bus.summary_cause_o  <= sum_cause_d;
                bus.summary_cycles_o <= cnt;
            end
        end
    end

`ifdef IBEX_FCOV_STALL_HIST_EN
    logic [NumStallCauses-1:0][HistCntW-1:0] hist;
    for (genvar c = 0; c < NumStallCauses; c++) begin : g_hist
        ibex_fcov_sat_counter #(.Width(HistCntW)) u_hist (
            .clk_i,
            .rst_ni,
            .clear (1'b0),
            .incr  (sum_valid_d && sum_cause_d == stall_cause_e'(3'(c))),
            .count (hist[c])
        );
    end
    assign bus.hist_o = hist;
`else
    assign bus.hist_o = '0;
`endif
endmodule

// File: tb/tb_ibex_uarch_fcov_probe.sv
// tb_ibex_uarch_fcov_probe: table vectors, corner sequences and random traffic against a
// per-instruction residency model.
module tb_ibex_uarch_fcov_probe;
    localparam int SW = 4;
    localparam int HW = 32;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    ibex_uarch_fcov_probe_if #(.StallCntW(SW), .HistCntW(HW)) bus ();
    ibex_uarch_fcov_probe #(.StallCntW(SW), .HistCntW(HW)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int cnt_cmp = 0;
    int cnt_bad = 0;

    logic        e_vif, e_vid, e_vwb, e_sv;
    logic [31:0] e_instr;
    logic [4:0]  e_stall;
    int          e_cause, e_cyc, len, first;
    int          hist[6];

    typedef struct {
        logic       idv;
        logic       done;
        logic [4:0] req;
        logic [4:0] stall;
        logic       sv;
        logic [2:0] cause;
        logic [3:0] cyc;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cnt_cmp++;
        if (act !== exp) begin
            cnt_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int prio(input logic [4:0] req);
        for (int i = 0; i < 5; i++) if (req[4-i]) return i + 1;
        return 6;
    endfunction

    task automatic model_reset();
        e_vif = 0; e_vid = 0; e_vwb = 0; e_sv = 0; e_instr = 0; e_stall = 0;
        e_cause = 0; e_cyc = 0; len = 0; first = 0;
        for (int i = 0; i < 6; i++) hist[i] = 0;
    endtask

    task automatic compare_all();
        chk("valid_if", 32'(bus.valid_if_o), 32'(e_vif));
        chk("valid_id", 32'(bus.valid_id_o), 32'(e_vid));
        chk("valid_wb", 32'(bus.valid_wb_o), 32'(e_vwb));
        chk("instr_id", bus.instr_id_o, e_instr);
        chk("stall_vec", 32'({bus.stall_id_ld_hz_o, bus.stall_id_mem_o, bus.stall_id_multdiv_o,
                              bus.stall_id_jump_o, bus.stall_id_branch_o}), 32'(e_stall));
        chk("summary_valid", 32'(bus.summary_valid_o), 32'(e_sv));
        chk("summary_cause", 32'(bus.summary_cause_o), 32'(e_cause));
        chk("summary_cycles", 32'(bus.summary_cycles_o), 32'(e_cyc));
`ifdef IBEX_FCOV_STALL_HIST_EN
        for (int i = 0; i < 6; i++) chk($sformatf("hist[%0d]", i), bus.hist_o[i*HW +: HW], 32'(hist[i]));
`else
        chk("hist_zero", 32'(|bus.hist_o), 32'd0);
`endif
    endtask

    // req bit order: {ld_hz, lsu_busy, multdiv_busy, jump, branch}
    task automatic step(input logic ifv, input logic idv, input logic done, input logic wbv,
                        input logic [4:0] req, input logic [31:0] instr);
        int c;
        bus.if_valid_i = ifv; bus.id_valid_i = idv; bus.id_done_i = done; bus.wb_valid_i = wbv;
        bus.id_instr_i = instr;
        {bus.ld_hz_i, bus.lsu_busy_i, bus.multdiv_busy_i, bus.jump_i, bus.branch_i} = req;
        @(posedge clk_i);
        e_vif = ifv; e_vid = idv; e_vwb = wbv;
        if (idv) e_instr = instr;
        c = prio(req);
        e_stall = (idv && !done && c < 6) ? 5'(5'b1 << (5 - c)) : 5'b0;
        e_sv = 0;
        if (idv && !done) begin
            if (len == 0) first = c;
            len++;
        end else if (idv) begin
            e_sv = 1;
            e_cause = (len == 0) ? 0 : first;
            e_cyc = (len > 15) ? 15 : len;
            len = 0;
            if (e_cause < 6) hist[e_cause]++;
        end else begin
            len = 0;
        end
        #1;
        compare_all();
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 5'b10000, 5'b10000, 1'b0, 3'd0, 4'd0};
        tbl[1]  = '{1'b1, 1'b0, 5'b10000, 5'b10000, 1'b0, 3'd0, 4'd0};
        tbl[2]  = '{1'b1, 1'b0, 5'b10000, 5'b10000, 1'b0, 3'd0, 4'd0};
        tbl[3]  = '{1'b1, 1'b1, 5'b10000, 5'b00000, 1'b1, 3'd1, 4'd3};
        tbl[4]  = '{1'b1, 1'b0, 5'b01101, 5'b01000, 1'b0, 3'd1, 4'd3};
        tbl[5]  = '{1'b1, 1'b0, 5'b00101, 5'b00100, 1'b0, 3'd1, 4'd3};
        tbl[6]  = '{1'b1, 1'b1, 5'b00101, 5'b00000, 1'b1, 3'd2, 4'd2};
        tbl[7]  = '{1'b1, 1'b0, 5'b00000, 5'b00000, 1'b0, 3'd2, 4'd2};
        tbl[8]  = '{1'b1, 1'b1, 5'b00000, 5'b00000, 1'b1, 3'd6, 4'd1};
        tbl[9]  = '{1'b0, 1'b0, 5'b11111, 5'b00000, 1'b0, 3'd6, 4'd1};
        tbl[10] = '{1'b1, 1'b0, 5'b00010, 5'b00010, 1'b0, 3'd6, 4'd1};
        tbl[11] = '{1'b1, 1'b1, 5'b00001, 5'b00000, 1'b1, 3'd4, 4'd1};
        tbl[12] = '{1'b1, 1'b1, 5'b00000, 5'b00000, 1'b1, 3'd0, 4'd0};

        // reset with every input high
        bus.if_valid_i = 1; bus.id_valid_i = 1; bus.id_done_i = 1; bus.wb_valid_i = 1;
        bus.id_instr_i = '1;
        {bus.ld_hz_i, bus.lsu_busy_i, bus.multdiv_busy_i, bus.jump_i, bus.branch_i} = '1;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        compare_all();
        rst_ni = 1;
        step(1, 1, 1, 1, 5'b11111, 32'hffff_ffff);

        foreach (tbl[i]) begin
            step(1, tbl[i].idv, tbl[i].done, 1, tbl[i].req, $urandom);
            chk($sformatf("tbl%0d_stall", i), 32'({bus.stall_id_ld_hz_o, bus.stall_id_mem_o,
                bus.stall_id_multdiv_o, bus.stall_id_jump_o, bus.stall_id_branch_o}), 32'(tbl[i].stall));
            chk($sformatf("tbl%0d_sv", i), 32'(bus.summary_valid_o), 32'(tbl[i].sv));
            chk($sformatf("tbl%0d_cause", i), 32'(bus.summary_cause_o), 32'(tbl[i].cause));
            chk($sformatf("tbl%0d_cyc", i), 32'(bus.summary_cycles_o), 32'(tbl[i].cyc));
        end

        // asynchronous reset in the middle of a stall
        step(1, 1, 0, 1, 5'b10000, $urandom);
        step(1, 1, 0, 1, 5'b10000, $urandom);
        #2 rst_ni = 0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk_i);
        #1 rst_ni = 1;
        step(0, 1, 1, 0, 5'b00000, $urandom);
        chk("post_reset_cause", 32'(bus.summary_cause_o), 32'd0);
        chk("post_reset_cyc", 32'(bus.summary_cycles_o), 32'd0);

        // saturation: 20 stall cycles on a 4-bit counter
        for (int i = 0; i < 20; i++) step(1, 1, 0, 1, 5'b00100, $urandom);
        step(1, 1, 1, 1, 5'b00000, $urandom);
        chk("sat_cyc", 32'(bus.summary_cycles_o), 32'd15);
        chk("sat_cause", 32'(bus.summary_cause_o), 32'd3);

        // flush after 5 stall cycles
        for (int i = 0; i < 5; i++) step(1, 1, 0, 1, 5'b01000, $urandom);
        step(1, 0, 0, 1, 5'b01000, $urandom);
        chk("flush_no_pulse", 32'(bus.summary_valid_o), 32'd0);
        step(1, 1, 1, 1, 5'b00000, $urandom);
        chk("flush_next_cause", 32'(bus.summary_cause_o), 32'd0);
        chk("flush_next_cyc", 32'(bus.summary_cycles_o), 32'd0);

        for (int n = 0; n < 400; n++) begin
            logic [4:0] rq;
            for (int b = 0; b < 5; b++) rq[b] = ($urandom_range(0, 9) < 3);
            step(1'($urandom), $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 4,
                 1'($urandom), rq, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_bad);
        $finish;
    end
endmodule
